// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 serial receiver, LSB first, idle-high line.
//
// The asynchronous rx line is brought into the clk domain through a two-stage
// synchroniser. Each bit is sampled around its middle with a 3-sample
// majority vote. A good frame updates data and pulses rx_done for one cycle;
// a frame whose stop bit votes low pulses frame_err and leaves data alone.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz (bit period = CLK_FREQ / baud)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, ACTIVE-HIGH despite the name
//   Baud_Set   in   baud select: 0=9600 1=19200 2=38400 3=57600 4=115200,
//                   5..7 fall back to 9600; latched at each start edge
//   rx         in   asynchronous serial input, idle high
//   data       out  last correctly received byte
//   rx_done    out  one-cycle strobe when data is updated
//   frame_err  out  one-cycle strobe when the stop bit votes low
//   rx_busy    out  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] Baud_Set,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam logic [15:0] BPS_9600   = 16'(CLK_FREQ / 9600);
   localparam logic [15:0] BPS_19200  = 16'(CLK_FREQ / 19200);
   localparam logic [15:0] BPS_38400  = 16'(CLK_FREQ / 38400);
   localparam logic [15:0] BPS_57600  = 16'(CLK_FREQ / 57600);
   localparam logic [15:0] BPS_115200 = 16'(CLK_FREQ / 115200);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // The port keeps its historical name; it is an active-high reset.
   logic srst;
   assign srst = rst_n;

   // ------------------------------------------------------------------
   // Synchroniser: sync_reg[1] is the usable line (rx_s), sync_reg[2] is
   // its one-cycle-old copy for falling-edge detection. Reset to 1 so the
   // line looks idle while the chain refills.
   // ------------------------------------------------------------------
   logic [2:0] sync_reg;
   logic       rx_s;
   logic       rx_s_d;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_reg <= 3'b111;
      end else begin
         sync_reg <= {sync_reg[1:0], rx};
      end
   end

   assign rx_s   = sync_reg[1];
   assign rx_s_d = sync_reg[2];

   // ------------------------------------------------------------------
   // Arming: the reset value of the chain is not a real observation of the
   // line. Only once rx_s carries a genuinely sampled high level may a
   // falling edge count as a start bit, so a line held low across reset
   // release cannot fake a frame.
   // ------------------------------------------------------------------
   logic [1:0] fill_cnt_reg;
   logic       armed_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         fill_cnt_reg <= 2'd0;
         armed_reg    <= 1'b0;
      end else begin
         if (fill_cnt_reg != 2'd2) begin
            fill_cnt_reg <= fill_cnt_reg + 2'd1;
         end
         if (fill_cnt_reg == 2'd2 && rx_s) begin
            armed_reg <= 1'b1;
         end
      end
   end

   logic start_edge;
   assign start_edge = armed_reg & rx_s_d & ~rx_s;

   // ------------------------------------------------------------------
   // Baud table lookup for the value that will be latched at a start edge.
   // ------------------------------------------------------------------
   logic [15:0] bps_sel;

   always_comb begin
      bps_sel = BPS_9600;
      case (Baud_Set)
         3'd1:    bps_sel = BPS_19200;
         3'd2:    bps_sel = BPS_38400;
         3'd3:    bps_sel = BPS_57600;
         3'd4:    bps_sel = BPS_115200;
         default: bps_sel = BPS_9600;
      endcase
   end

   // ------------------------------------------------------------------
   // Receive FSM state and datapath registers
   // ------------------------------------------------------------------
   state_t      state_reg,     state_next;
   logic [15:0] bps_reg,       bps_next;
   logic [15:0] div_cnt_reg,   div_cnt_next;
   logic [2:0]  bit_cnt_reg,   bit_cnt_next;
   logic [7:0]  shift_reg,     shift_next;
   logic [1:0]  samp_reg,      samp_next;
   logic [7:0]  data_reg,      data_next;
   logic        rx_done_reg,   rx_done_next;
   logic        frame_err_reg, frame_err_next;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg     <= IDLE;
         bps_reg       <= 16'd0;
         div_cnt_reg   <= 16'd0;
         bit_cnt_reg   <= 3'd0;
         shift_reg     <= 8'h00;
         samp_reg      <= 2'b00;
         data_reg      <= 8'h00;
         rx_done_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bps_reg       <= bps_next;
         div_cnt_reg   <= div_cnt_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         samp_reg      <= samp_next;
         data_reg      <= data_next;
         rx_done_reg   <= rx_done_next;
         frame_err_reg <= frame_err_next;
      end
   end

   // Sample point decoding. The first two votes are stored; the third is
   // the live rx_s on the decision cycle, so the result is ready at S+1.
   logic [15:0] half;
   logic        at_samp0;
   logic        at_samp1;
   logic        at_vote;
   logic        at_last;
   logic        vote;

   assign half     = {1'b0, bps_reg[15:1]};
   assign at_samp0 = (div_cnt_reg == half - 16'd1);
   assign at_samp1 = (div_cnt_reg == half);
   assign at_vote  = (div_cnt_reg == half + 16'd1);
   assign at_last  = (div_cnt_reg == bps_reg - 16'd1);
   assign vote     = (samp_reg[0] & samp_reg[1]) |
                     (samp_reg[0] & rx_s) |
                     (samp_reg[1] & rx_s);

   always_comb begin
      state_next     = state_reg;
      bps_next       = bps_reg;
      div_cnt_next   = div_cnt_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      samp_next      = samp_reg;
      data_next      = data_reg;
      rx_done_next   = 1'b0;
      frame_err_next = 1'b0;

      // Bit-period divider and vote sample capture run in every busy state.
      if (state_reg != IDLE) begin
         div_cnt_next = at_last ? 16'd0 : div_cnt_reg + 16'd1;
         if (at_samp0) begin
            samp_next[0] = rx_s;
         end
         if (at_samp1) begin
            samp_next[1] = rx_s;
         end
      end

      case (state_reg)
         IDLE: begin
            div_cnt_next = 16'd0;
            if (start_edge) begin
               state_next   = START;
               bps_next     = bps_sel;
               bit_cnt_next = 3'd0;
            end
         end

         START: begin
            if (at_vote && vote) begin
               // Line was back high at mid start bit: a glitch, not a frame.
               state_next   = IDLE;
               div_cnt_next = 16'd0;
            end else if (at_last) begin
               state_next   = DATA;
               bit_cnt_next = 3'd0;
            end
         end

         DATA: begin
            if (at_vote) begin
               shift_next[bit_cnt_reg] = vote;
            end
            if (at_last) begin
               if (bit_cnt_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end
         end

         STOP: begin
            // Leave at mid stop bit so an immediately following start bit
            // is seen from IDLE.
            if (at_vote) begin
               if (vote) begin
                  data_next    = shift_reg;
                  rx_done_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
               end
               state_next   = IDLE;
               div_cnt_next = 16'd0;
            end
         end

         default: begin
            state_next   = IDLE;
            div_cnt_next = 16'd0;
         end
      endcase
   end

   assign data      = data_reg;
   assign rx_done   = rx_done_reg;
   assign frame_err = frame_err_reg;
   assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
// A serial driver plays the transmitter; every frame it launches is pushed
// into an expectation queue (byte, good/bad stop, launch cycle, bit period).
// One compare process checks the DUT outputs against that model every cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FREQ = 2_000_000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] Baud_Set;
   logic       rx;
   logic [7:0] data;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Baud_Set  (Baud_Set),
      .rx        (rx),
      .data      (data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      bit         err;
      int         fall;
      int         bps;
   } frame_t;

   frame_t     exp_q[$];
   frame_t     cur;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_data = 8'h00;
   logic       rst_q = 1'b1;
   logic       busy_prev = 1'b0;
   int         last_lat = 0;
   int         last_done_cyc = 0;

   function automatic int bps_of(input logic [2:0] sel);
      int rate;
      case (sel)
         3'd1:    rate = 19200;
         3'd2:    rate = 38400;
         3'd3:    rate = 57600;
         3'd4:    rate = 115200;
         default: rate = 9600;
      endcase
      return CLK_FREQ / rate;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk_near(input string name, input int act, input int req, input int tol);
      checks++;
      if (act < req - tol || act > req + tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
      end
   endtask

   // ---------------- compare process ----------------
   always @(posedge clk) rst_q <= rst_n;

   always @(negedge clk) begin
      if (rst_q) begin
         exp_q.delete();
         exp_data = 8'h00;
         chk("reset_data", int'(data), 0);
         chk("reset_rx_done", int'(rx_done), 0);
         chk("reset_frame_err", int'(frame_err), 0);
         chk("reset_rx_busy", int'(rx_busy), 0);
      end else begin
         if (rx_done && frame_err) chk("done_and_err_together", 1, 0);
         if (rx_done || frame_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               last_lat = cyc - cur.fall;
               last_done_cyc = cyc;
               chk("strobe_kind_err", int'(frame_err), int'(cur.err));
               chk_near("strobe_latency", last_lat, 9 * cur.bps + cur.bps / 2 + 5, 2);
               if (rx_done && !cur.err) exp_data = cur.b;
               $display("frame %s byte=%02h data=%02h latency=%0d",
                        frame_err ? "stop-low" : "good", cur.b, data, last_lat);
            end
         end
         chk("data_hold", int'(data), int'(exp_data));
         if (rx_done) begin
            chk("busy_low_at_done", int'(rx_busy), 0);
            chk("busy_before_done", int'(busy_prev), 1);
         end
      end
      busy_prev = rx_busy;
   end

   // ---------------- stimulus ----------------
   // Called and returning at posedge+1. per100 = bit period x100 in cycles,
   // so fractional rates model a mismatched transmitter. abort_bit < 8
   // asserts reset in the middle of that data bit and abandons the frame.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per100,
                             input int abort_bit, input bit chg_baud);
      logic [9:0] bits;
      frame_t     f;
      int         t0;
      bits   = {stop_ok, b, 1'b0};
      t0     = cyc;
      f.b    = b;
      f.err  = !stop_ok;
      f.fall = cyc;
      f.bps  = bps_of(Baud_Set);
      exp_q.push_back(f);
      for (int k = 0; k < 10; k++) begin
         rx = bits[k];
         if (chg_baud && k == 3) Baud_Set = 3'd0;
         if (k == abort_bit + 1) begin
            while ((cyc - t0) < (k * per100 + per100 / 2 + 50) / 100) begin
               @(posedge clk); #1;
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b0;
            rx = 1'b1;
            return;
         end
         while ((cyc - t0) < ((k + 1) * per100 + 50) / 100) begin
            @(posedge clk); #1;
         end
      end
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 4000;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
      idle(4);
      chk({name, "_busy_idle"}, int'(rx_busy), 0);
   endtask

   logic [7:0] lb_bytes [4];
   bit         busy_seen;
   int         first_done;
   int         bps;

   initial begin
      lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'hA5; lb_bytes[3] = 8'h3C;
      rst_n    = 1'b1;
      rx       = 1'b1;
      Baud_Set = 3'd4;
      idle(3);
      rst_n = 1'b0;
      idle(10);

      // Single byte at 115200; Baud_Set changed mid-frame must not matter.
      bps = bps_of(3'd4);
      send_frame(8'h55, 1'b1, bps * 100, 99, 1'b1);
      Baud_Set = 3'd4;
      drain("single");
      chk("single_data", int'(data), 8'h55);
      chk("single_latency", last_lat, 166);

      // Loopback over all rates, nominal then +/-2% transmitter error.
      for (int pass = 0; pass < 2; pass++) begin
         for (int sel = 0; sel < 5; sel++) begin
            Baud_Set = 3'(sel);
            bps = bps_of(3'(sel));
            for (int i = 0; i < 4; i++) begin
               send_frame(lb_bytes[i], 1'b1,
                          (pass == 0) ? bps * 100 : bps * ((sel % 2) ? 98 : 102), 99, 1'b0);
               idle(2 * bps);
               drain("loopback");
               chk("loopback_data", int'(data), int'(lb_bytes[i]));
            end
         end
      end

      // Glitch: 5-cycle low pulse at 17 clk/bit, then a real 0x81.
      Baud_Set  = 3'd4;
      bps       = bps_of(3'd4);
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (5) begin @(posedge clk); #1; busy_seen |= rx_busy; end
      rx = 1'b1;
      repeat (20) begin @(posedge clk); #1; busy_seen |= rx_busy; end
      chk("glitch_busy_pulse", int'(busy_seen), 1);
      idle(3 * bps);
      chk("glitch_busy_idle", int'(rx_busy), 0);
      chk("glitch_data_kept", int'(data), 8'h3C);
      send_frame(8'h81, 1'b1, bps * 100, 99, 1'b0);
      drain("after_glitch");
      chk("after_glitch_data", int'(data), 8'h81);

      // Framing error: stop bit low, data must keep 0x81.
      idle(bps);
      send_frame(8'hC3, 1'b0, bps * 100, 99, 1'b0);
      idle(2 * bps);
      drain("frame_err");
      chk("frame_err_data_kept", int'(data), 8'h81);

      // Back-to-back, no idle between frames.
      send_frame(8'h12, 1'b1, bps * 100, 99, 1'b0);
      first_done = last_done_cyc;
      send_frame(8'h34, 1'b1, bps * 100, 99, 1'b0);
      drain("b2b");
      chk("b2b_data", int'(data), 8'h34);
      chk_near("b2b_spacing", last_done_cyc - first_done, 170, 2);

      // Reset during bit 4 of 0x99, then a fresh 0x5A.
      send_frame(8'h99, 1'b1, bps * 100, 4, 1'b0);
      idle(10);
      chk("post_reset_data", int'(data), 8'h00);
      chk("post_reset_busy", int'(rx_busy), 0);
      send_frame(8'h5A, 1'b1, bps * 100, 99, 1'b0);
      drain("after_reset");
      chk("after_reset_data", int'(data), 8'h5A);

      idle(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
